// File: rtl/ped_request_ctrl.sv
// Pedestrian request / walk-interval controller: debounced button -> latched request -> timed WALK then CLEAR.
// Latency: press to ped_req = 2 sync + DB_CYCLES + 1 cycles; grant to pedSignal = 1 cycle; ped_done 1 cycle after CLEAR ends.
// Backpressure: none; the request is held in PENDING until ped_grant, and extra presses are folded into the 'again' flag.
// Optional feature macro: PED_FLASH_EN (flashing don't-walk during CLEAR; walk_flash tied low when undefined).
module ped_request_ctrl #(
   parameter int WALK_TIME  = 12,
   parameter int CLEAR_TIME = 6,
   parameter int DB_CYCLES  = 4,
   parameter int CNT_W      = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             button,
   input  logic             tick,
   input  logic             ped_grant,
   output logic             ped_req,
   output logic             pedSignal,
   output logic             walk_flash,
   output logic             ped_done,
   output logic [CNT_W-1:0] time_left
);

   localparam int              DB_W       = $clog2(DB_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TIME - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_TIME - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PENDING = 2'd1,
      S_WALK    = 2'd2,
      S_CLEAR   = 2'd3
   } state_t;

   // button path state
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            db_q, db_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            press_q, press_d;

   // controller state
   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            again_q, again_d;
   logic            ped_req_q, ped_req_d;
   logic            ped_sig_q, ped_sig_d;
   logic            ped_done_q, ped_done_d;

   // interval end: last tick of the current WALK or CLEAR interval
   logic            interval_end;
   assign interval_end = tick && (cnt_q == '0);

   // Synchronize the button, then accept a new level only after DB_CYCLES consecutive differing samples.
   // The press is registered once more so the FSM sees it one cycle after the debounced level rises.
   always_comb begin
      sync1_d  = button;
      sync2_d  = sync1_q;
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync2_q != db_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_d     = sync2_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
      press_d = db_d & ~db_q;
   end

   // Button path registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_q     <= 1'b0;
         db_cnt_q <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_q     <= db_d;
         db_cnt_q <= db_cnt_d;
         press_q  <= press_d;
      end
   end

   // Next-state, interval counter and again-flag logic; grants outside PENDING fall through untouched.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      again_d    = again_q;
      ped_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press_q) begin
               state_d = S_PENDING;
               again_d = 1'b0;
            end
         end
         S_PENDING: begin
            if (ped_grant) begin
               state_d = S_WALK;
               cnt_d   = WALK_LOAD;
            end
         end
         S_WALK: begin
            if (press_q) again_d = 1'b1;
            if (interval_end) begin
               state_d = S_CLEAR;
               cnt_d   = CLEAR_LOAD;
            end else if (tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_CLEAR: begin
            if (press_q) again_d = 1'b1;
            if (interval_end) begin
               ped_done_d = 1'b1;
               cnt_d      = '0;
               // a press landing in the exit cycle still counts as a repeat request
               if (again_q || press_q) begin
                  state_d = S_PENDING;
               end else begin
                  state_d = S_IDLE;
               end
               again_d = 1'b0;
            end else if (tick) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            again_d = 1'b0;
         end
      endcase
      ped_req_d = (state_d == S_PENDING);
      ped_sig_d = (state_d == S_WALK);
   end

   // Controller registers; reset drops any pending request and suppresses ped_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         again_q    <= 1'b0;
         ped_req_q  <= 1'b0;
         ped_sig_q  <= 1'b0;
         ped_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         again_q    <= again_d;
         ped_req_q  <= ped_req_d;
         ped_sig_q  <= ped_sig_d;
         ped_done_q <= ped_done_d;
      end
   end

`ifdef PED_FLASH_EN
   logic flash_q, flash_d;

   // Flash starts high on CLEAR entry, toggles per tick inside CLEAR, and is low everywhere else.
   always_comb begin
      flash_d = 1'b0;
      if (state_q == S_WALK && interval_end) begin
         flash_d = 1'b1;
      end else if (state_q == S_CLEAR && !interval_end) begin
         flash_d = tick ? ~flash_q : flash_q;
      end
   end

   // Flash toggle register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flash_q <= 1'b0;
      end else begin
         flash_q <= flash_d;
      end
   end

   assign walk_flash = flash_q;
`else
   assign walk_flash = 1'b0;
`endif

   assign ped_req   = ped_req_q;
   assign pedSignal = ped_sig_q;
   assign ped_done  = ped_done_q;
   assign time_left = (state_q == S_WALK || state_q == S_CLEAR) ? (cnt_q + CNT_W'(1)) : '0;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: vector table, directed corner sequences and a random run against a behavioural model.
// Latency: each vector drives inputs on the falling edge and samples outputs 1 time unit after the rising edge.
// Backpressure: not applicable; every wait is bounded by a fixed cycle budget.
module tb_ped_request_ctrl;

   localparam int WALK_TIME  = 12;
   localparam int CLEAR_TIME = 6;
   localparam int DB_CYCLES  = 4;
   localparam int CNT_W      = 7;
`ifdef PED_FLASH_EN
   localparam bit FLASH_ON = 1'b1;
`else
   localparam bit FLASH_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             button, tick, ped_grant;
   logic             ped_req, pedSignal, walk_flash, ped_done;
   logic [CNT_W-1:0] time_left;

   int vectors     = 0;
   int miscompares = 0;

   ped_request_ctrl #(
      .WALK_TIME (WALK_TIME),
      .CLEAR_TIME(CLEAR_TIME),
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .button    (button),
      .tick      (tick),
      .ped_grant (ped_grant),
      .ped_req   (ped_req),
      .pedSignal (pedSignal),
      .walk_flash(walk_flash),
      .ped_done  (ped_done),
      .time_left (time_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // one clock: drive on the falling edge, sample just after the rising edge
   task automatic cyc(input logic b, input logic t, input logic g);
      @(negedge clk);
      button    = b;
      tick      = t;
      ped_grant = g;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; button = 1'b0; tick = 1'b0; ped_grant = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // clean press: long enough to debounce high, then long enough to debounce low again
   task automatic press_button();
      for (int i = 0; i < DB_CYCLES + 4; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < DB_CYCLES + 4; i++) cyc(1'b0, 1'b0, 1'b0);
   endtask

   function automatic int pack_out();
      return (int'(ped_req) << 10) | (int'(pedSignal) << 9) | (int'(walk_flash) << 8) |
             (int'(ped_done) << 7) | int'(time_left);
   endfunction

   // ---------------- behavioural reference model ----------------
   // phase: 0 idle, 1 pending, 2 walk, 3 clear; rem = ticks still owed in the interval
   int   m_s1, m_s2, m_db, m_press, m_phase, m_rem, m_again, m_done;
   int   m_hist[$];

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0;
      m_phase = 0; m_rem = 0; m_again = 0; m_done = 0;
      m_hist.delete();
   endtask

   task automatic model_step(input int b, input int t, input int g);
      int flip;
      int press;
      flip = 0;
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB_CYCLES) void'(m_hist.pop_front());
      if (m_hist.size() == DB_CYCLES) begin
         flip = 1;
         foreach (m_hist[i]) if (m_hist[i] == m_db) flip = 0;
      end
      press  = m_press;
      m_done = 0;
      case (m_phase)
         0: if (press) begin m_phase = 1; m_again = 0; end
         1: if (g) begin m_phase = 2; m_rem = WALK_TIME; end
         2: begin
            if (press) m_again = 1;
            if (t) begin
               m_rem--;
               if (m_rem == 0) begin m_phase = 3; m_rem = CLEAR_TIME; end
            end
         end
         default: begin
            if (press) m_again = 1;
            if (t) begin
               m_rem--;
               if (m_rem == 0) begin
                  m_done  = 1;
                  m_phase = m_again ? 1 : 0;
                  m_again = 0;
               end
            end
         end
      endcase
      m_press = (flip && m_db == 0) ? 1 : 0;
      if (flip) m_db = 1 - m_db;
      m_s2 = m_s1;
      m_s1 = b;
   endtask

   function automatic int model_out();
      int req, sig, fl, tl;
      req = (m_phase == 1);
      sig = (m_phase == 2);
      tl  = (m_phase >= 2) ? m_rem : 0;
      fl  = (FLASH_ON && m_phase == 3 && ((CLEAR_TIME - m_rem) % 2 == 0)) ? 1 : 0;
      return (req << 10) | (sig << 9) | (fl << 8) | (m_done << 7) | tl;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic b, t, g;
      logic exp_req, exp_sig;
      int   exp_tl;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int seen, done_cnt, max_req, lvl, hold;
      logic rb, rt, rg;

      // button held high from row 0; row 6 is the 7th rising edge after the first high sample
      tbl[0]  = '{1, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 0, 0, 0, 0, 0};
      tbl[4]  = '{1, 0, 0, 0, 0, 0};
      tbl[5]  = '{1, 0, 0, 0, 0, 0};
      tbl[6]  = '{1, 0, 0, 1, 0, 0};
      tbl[7]  = '{1, 1, 0, 1, 0, 0};
      tbl[8]  = '{0, 1, 1, 0, 1, 12};   // tick in the grant cycle is not counted
      tbl[9]  = '{0, 1, 0, 0, 1, 11};
      tbl[10] = '{0, 0, 1, 0, 1, 11};   // grant in WALK ignored
      tbl[11] = '{0, 1, 0, 0, 1, 10};

      rst_n = 1'b0; button = 1'b0; tick = 1'b0; ped_grant = 1'b0;
      #2;
      check("async_reset_outputs", pack_out(), 0);
      do_reset();
      #1;
      check("reset_outputs", pack_out(), 0);

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].b, tbl[i].t, tbl[i].g);
         check($sformatf("tbl%0d_req", i), int'(ped_req), int'(tbl[i].exp_req));
         check($sformatf("tbl%0d_sig", i), int'(pedSignal), int'(tbl[i].exp_sig));
         check($sformatf("tbl%0d_tl", i), int'(time_left), tbl[i].exp_tl);
      end

      // short glitches never debounce into a press
      do_reset();
      max_req = 0;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0, 1'b0); if (ped_req) max_req = 1; end
         for (int i = 0; i < 3; i++) begin cyc(1'b0, 1'b0, 1'b0); if (ped_req) max_req = 1; end
      end
      for (int i = 0; i < 10; i++) begin cyc(1'b0, 1'b0, 1'b0); if (ped_req) max_req = 1; end
      check("glitch_no_req", max_req, 0);

      // full walk/clear service with a tick every 10 cycles; grant in IDLE is dropped
      do_reset();
      cyc(1'b0, 1'b0, 1'b1);
      check("idle_grant_ignored", int'(ped_req) + int'(pedSignal), 0);
      press_button();
      check("press_req", int'(ped_req), 1);
      cyc(1'b0, 1'b0, 1'b1);
      check("grant_req_low", int'(ped_req), 0);
      for (int k = 0; k < WALK_TIME; k++) begin
         check($sformatf("walk%0d_sig", k), int'(pedSignal), 1);
         check($sformatf("walk%0d_tl", k), int'(time_left), WALK_TIME - k);
         for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      check("clear_sig_low", int'(pedSignal), 0);
      for (int k = 0; k < CLEAR_TIME; k++) begin
         check($sformatf("clear%0d_tl", k), int'(time_left), CLEAR_TIME - k);
         check($sformatf("clear%0d_flash", k), int'(walk_flash), (FLASH_ON && (k % 2 == 0)) ? 1 : 0);
         check($sformatf("clear%0d_nodone", k), int'(ped_done), 0);
         for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      check("done_pulse", pack_out(), 1 << 7);
      cyc(1'b0, 1'b0, 1'b0);
      check("after_done_idle", pack_out(), 0);

      // press during WALK re-queues the request after CLEAR
      do_reset();
      press_button();
      cyc(1'b0, 1'b0, 1'b1);
      press_button();
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (ped_done) seen = 1;
      end
      check("again_done_seen", seen, 1);
      check("again_back_pending", int'(ped_req) + 2 * int'(pedSignal), 1);

      // reset in the middle of WALK aborts at once and never issues ped_done
      do_reset();
      press_button();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("pre_abort_walk", int'(pedSignal), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_async_zero", pack_out(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (ped_done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_idle", pack_out(), 0);

      // random run against the reference model
      do_reset();
      model_reset();
      lvl = 0;
      hold = 0;
      for (int n = 0; n < 4000; n++) begin
         if (hold == 0) begin
            lvl  = $urandom_range(0, 1);
            hold = $urandom_range(1, 12);
         end
         hold--;
         rb = lvl[0];
         rt = ($urandom_range(0, 3) == 0);
         rg = ($urandom_range(0, 5) == 0);
         model_step(int'(rb), int'(rt), int'(rg));
         cyc(rb, rt, rg);
         check($sformatf("rand%0d", n), pack_out(), model_out());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ped_request_ctrl.md
# ped_request_ctrl

Pedestrian-side request and walk-interval controller for the intersection. It debounces the crosswalk push-button and raises a latched service request to the phase controller. On grant it drives `pedSignal` into the pedestrian output decoder for a timed walk interval, then a clearance interval, and reports completion. It sits between the button pad and the phase controller / Pedestrian decoder pair.

## Interface
- `WALK_TIME`, 12: walk interval length in `tick` periods, 1..2^CNT_W-1.
- `CLEAR_TIME`, 6: clearance (don't-walk) interval in `tick` periods, 1..2^CNT_W-1.
- `DB_CYCLES`, 4: number of consecutive identical synchronized samples required to accept a new button level, ≥1.
- `CNT_W`, 7: interval counter width.

- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `button` input 1: raw push-button, asynchronous to `clk`, active-high.
- `tick` input 1: one-cycle timebase enable from the system timer.
- `ped_grant` input 1: one-cycle grant pulse from the phase controller.
- `ped_req` output 1: pending pedestrian service request.
- `pedSignal` output 1: walk active; feeds the Pedestrian decoder.
- `walk_flash` output 1: flashing don't-walk indication during clearance.
- `ped_done` output 1: one-cycle pulse when clearance ends.
- `time_left` output CNT_W: remaining ticks in the current WALK/CLEAR interval, 0 otherwise.

## Operation
- Button path:
  - 2-flop synchronizer feeds a debounce counter.
  - The debounced level changes only after `DB_CYCLES` consecutive synchronized samples that differ from the current debounced level.
  - A debounced rising edge is a "press".
- States and transitions:
  - IDLE → PENDING on a press.
  - PENDING holds `ped_req`=1; → WALK on `ped_grant`.
  - WALK: `pedSignal`=1.
  - CLEAR: `pedSignal`=0, `walk_flash` per Configuration.
  - CLEAR exits when its count expires: → PENDING if `again`=1, else → IDLE.
- `ped_grant` is ignored in every state except PENDING.
- Presses during PENDING have no effect.
- Presses during WALK or CLEAR set the `again` flag.
  - `again` is cleared on entering PENDING.
- Interval counter:
  - Loaded with WALK_TIME-1 on entry to WALK, and with CLEAR_TIME-1 on entry to CLEAR.
  - Decrements on `tick`.
  - When the count is 0 and `tick`=1, the interval ends.
  - Each interval therefore spans exactly its programmed number of ticks after entry.
  - `time_left` = count+1 in WALK/CLEAR, 0 in IDLE/PENDING.
  - A `tick` in the entry cycle is not counted.
- `ped_done` = 1 in the cycle after CLEAR exits.
- `ped_req` is registered: 1 exactly while in PENDING.

## Timing
- Reset values: state IDLE, `ped_req`=0, `pedSignal`=0, `walk_flash`=0, `ped_done`=0, `time_left`=0, `again`=0, synchronizer/debounce = 0.
- `rst_n` low mid-interval aborts immediately to IDLE. No `ped_done` is issued, and pending/`again` requests are dropped.
- Button press to `ped_req`: 2 (sync) + `DB_CYCLES` + 1 cycles after the first high sample.
- `ped_grant` at cycle n (in PENDING): `pedSignal`=1 and `ped_req`=0 from cycle n+1.
- Final tick of WALK at cycle n: `pedSignal`=0 from n+1, and CLEAR is entered.
- Final tick of CLEAR at cycle n: `ped_done`=1 at n+1 only.
- A press and `ped_grant` in the same cycle while in IDLE: the press is taken and the grant is dropped.
- Glitches shorter than `DB_CYCLES` cycles never produce a press.

## Configuration
- `PED_FLASH_EN` defined:
  - `walk_flash` is set to 1 on entry to CLEAR and toggles on every `tick` during CLEAR.
  - It is forced to 0 outside CLEAR.
- `PED_FLASH_EN` undefined:
  - `walk_flash` is constant 0.
  - The toggle register is not instantiated.
  - All other behaviour is identical.

## Test plan
- Reset, then hold `button` high 10 cycles (DB_CYCLES=4) → `ped_req`=1 at cycle 7 after the first high sample; `pedSignal`=0.
- Button pulses of 3 cycles, repeated with 3-cycle gaps → `ped_req` never asserts.
- Grant in PENDING with tick every 10 cycles → `pedSignal`=1 for exactly 12 ticks, `time_left` counts 12..1, then CLEAR for 6 ticks, then a single-cycle `ped_done`, then IDLE.
- Press during WALK → after CLEAR, `ped_done` pulses and the state returns to PENDING with `ped_req`=1; `ped_grant` in IDLE and in WALK is ignored.
- Assert `rst_n` low in the middle of WALK → all outputs 0 asynchronously, no `ped_done`, IDLE after release.
- With `PED_FLASH_EN` defined, `walk_flash` follows 1,0,1,0,1,0 over the 6 CLEAR ticks. Undefined: `walk_flash` stays 0.
